mem_responder: RTL
==================

# mem_responder

Multi-cycle memory responder that sits on the far side of the CPU's instruction-fetch and data-access ports. It replaces the zero-latency memory model with a shared single-port word array. Two request/acknowledge channels, one for instruction reads and one for data reads/writes, are arbitrated onto that array. Each access completes after a programmable number of wait states, which lets the CPU side be developed and verified against realistic stall behaviour.

## Interface
- `ADDR_W`, 10: byte-address width on both channels.
- `DATA_W`, 32: word width.
- `LATENCY`, 2: wait states per access. Legal range 0..15.
- `DEPTH`, 2**(ADDR_W-2): number of words in the array.

- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_req` in 1: instruction read request. Level signal.
- `i_addr` in ADDR_W: instruction byte address.
- `i_ack` out 1: one-cycle completion pulse for the instruction channel.
- `i_rdata` out DATA_W: instruction word, valid while `i_ack`=1.
- `d_req` in 1: data request. Level signal.
- `d_we` in 1: 1 = write, 0 = read.
- `d_addr` in ADDR_W: data byte address.
- `d_wdata` in DATA_W: write data.
- `d_ack` out 1: one-cycle completion pulse for the data channel.
- `d_rdata` out DATA_W: read data (or the written word on writes), valid while `d_ack`=1.
- `busy` out 1: high in every state except IDLE.

## Operation
- Word index = addr[ADDR_W-1:2]. addr[1:0] is ignored; byte enables are not supported.
- The FSM has three states:
  - IDLE: sample requests. If a request is granted, latch channel, address, `d_we` and `d_wdata`, load the counter with LATENCY and go to WAIT. If LATENCY=0, go directly to ACCESS.
  - WAIT: decrement the counter each cycle. When the counter reaches 0, go to ACCESS.
  - ACCESS: perform the array read or write, assert the granted channel's ack and rdata register, then return to IDLE unconditionally.
- Arbitration happens in IDLE only.
  - If only one req is high, that channel is granted.
  - If both are high, the channel not granted last time wins. The `last_grant` flop resets to instruction, so data wins the first tie.
  - A request arriving during WAIT or ACCESS is not seen until the next IDLE.
- Request fields are captured at grant. Changes to address or data on the requester side after grant have no effect.
- Write: `mem[idx] <= d_wdata` at the ACCESS edge. `d_rdata` returns the written word.
- Read: rdata equals the array content at the ACCESS edge.
- `i_rdata` and `d_rdata` are registered. They update only on their own ack cycle and hold their value otherwise.
- Requester rule: hold req and fields stable until ack is sampled high, then deassert req on that same edge. A req still high in the IDLE cycle after ack is treated as a new request.
- Reset, at any time including mid-transaction:
  - State returns to IDLE, counter to 0, `last_grant` to instruction.
  - `i_ack`, `d_ack` and `busy` go to 0; `i_rdata` and `d_rdata` go to 0.
  - A pending write that has not yet reached ACCESS is discarded.
  - Array contents are not cleared.

## Timing
- Latency from the req-sample edge in IDLE to ack high is LATENCY+1 cycles.
- Ack width is exactly 1 cycle. At most one ack is high in any cycle.
- Minimum issue interval per transaction is LATENCY+2 cycles, which includes the mandatory IDLE cycle.
- `busy` rises on the edge after grant and falls on the edge that leaves ACCESS.
- Tie case: both channels complete within 2*(LATENCY+2) cycles of both reqs being sampled.

## Structure
- Package `mem_responder_pkg`:
  - State enum {IDLE, WAIT, ACCESS}.
  - Grant encoding constants GNT_I=0, GNT_D=1.
  - Counter width constant LAT_W=4.
- Sub-module `rr_arb2`: two-request round-robin arbiter holding `last_grant`. Its update is enabled only on grant in IDLE.
- The array is an unreset register array in the top module.

## Test plan
1. Reset, then d write 0xDEADBEEF to 0x010, then d read 0x010:
   - `d_ack` arrives 3 cycles after each sample (LATENCY=2).
   - The read returns 0xDEADBEEF.
2. Address aliasing: i read 0x011, 0x012 and 0x013 after the write in test 1 → each returns 0xDEADBEEF.
3. `i_req` and `d_req` raised on the same cycle:
   - Data is acked first, instruction second.
   - A repeat tie is then won by instruction, with no overlap of acks.
4. LATENCY=0 build, back-to-back reads with req held one cycle too long → a second ack follows after a 1-cycle IDLE gap. The ack period is exactly 2 cycles.
5. Assert `rst_n`=0 during WAIT of a write of 0x12345678 to 0x020:
   - No ack is produced, and the outputs read 0.
   - A subsequent read of 0x020 returns the prior content, not 0x12345678.
6. Change `d_addr` and `d_wdata` during WAIT → the access uses the values latched at grant.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared types and constants for the multi-cycle memory responder
// Purpose: FSM state encoding, channel grant encoding and wait-state counter width.
// Ports:   none (package).
package mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    localparam int LAT_W = 4;

endpackage

// File: rtl/mem_responder_arb.sv
// rtl/mem_responder_arb.sv - two-request round-robin arbiter for the instruction and data channels
// Purpose: picks a channel; on a tie the channel not granted last time wins.
// Ports:   clk, rst_n          - clock, async active-low reset
//          en_i                - allow last_grant to update (responder is IDLE)
//          req_i_i, req_d_i    - instruction / data requests
//          gnt_valid_o, gnt_o  - some request is present / granted channel (GNT_I or GNT_D)
module rr_arb2
    import mem_responder_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic req_i_i,
    input  logic req_d_i,
    output logic gnt_valid_o,
    output logic gnt_o
);

    logic last_q;

    always_comb begin
        gnt_valid_o = req_i_i | req_d_i;
        if (req_i_i && req_d_i) begin
            gnt_o = ~last_q;
        end else if (req_d_i) begin
            gnt_o = GNT_D;
        end else begin
            gnt_o = GNT_I;
        end
    end

    // Resets to instruction so that data wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= GNT_I;
        end else if (en_i && gnt_valid_o) begin
            last_q <= gnt_o;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - shared single-port word array behind arbitrated instruction/data channels
// Purpose: each granted access completes after LATENCY wait states plus one access cycle.
// Ports:   clk, rst_n                         - clock, async active-low reset
//          i_req, i_addr, i_ack, i_rdata      - instruction read channel
//          d_req, d_we, d_addr, d_wdata,
//          d_ack, d_rdata                     - data read/write channel
//          busy                               - high whenever the FSM is not IDLE
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 2 ** (ADDR_W - 2)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              busy
);

    localparam int IDX_W = ADDR_W - 2;

    state_e             state_q;
    logic [LAT_W-1:0]   cnt_q;
    logic [LAT_W-1:0]   cnt_d;
    logic               ch_q;
    logic [IDX_W-1:0]   idx_q;
    logic               we_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               i_ack_q;
    logic               d_ack_q;
    logic [DATA_W-1:0]  i_rdata_q;
    logic [DATA_W-1:0]  d_rdata_q;
    logic               gnt_valid;
    logic               gnt;

    // Word array deliberately has no reset: contents survive rst_n.
    logic [DATA_W-1:0]  mem_q [DEPTH];

    // Byte lanes within a word are not addressable.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

    rr_arb2 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (state_q == ST_IDLE),
        .req_i_i     (i_req),
        .req_d_i     (d_req),
        .gnt_valid_o (gnt_valid),
        .gnt_o       (gnt)
    );

    assign cnt_d = cnt_q - LAT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ch_q      <= GNT_I;
            idx_q     <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        // Capture everything now; requester-side changes after grant are ignored.
                        ch_q    <= gnt;
                        idx_q   <= (gnt == GNT_D) ? d_addr[ADDR_W-1:2] : i_addr[ADDR_W-1:2];
                        we_q    <= (gnt == GNT_D) && d_we;
                        wdata_q <= d_wdata;
                        cnt_q   <= LAT_W'(LATENCY);
                        state_q <= (LATENCY == 0) ? ST_ACCESS : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_d;
                    if (cnt_d == '0) begin
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    state_q <= ST_IDLE;
                    if (ch_q == GNT_D) begin
                        d_ack_q   <= 1'b1;
                        d_rdata_q <= we_q ? wdata_q : mem_q[idx_q];
                    end else begin
                        i_ack_q   <= 1'b1;
                        i_rdata_q <= mem_q[idx_q];
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_ACCESS && ch_q == GNT_D && we_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign busy    = (state_q != ST_IDLE);

endmodule
